trace_sink: RTL and testbench

Receives 256-bit CPU trace packets (`pkg_valid`/`pkg`) from the core tracer, filters them by packet type, and buffers them in a small FIFO. It serializes each buffered packet into eight 32-bit words on a valid/ready stream toward the debug/trace export path. The CPU side has no backpressure, so packets that arrive while the FIFO is full are dropped and flagged.

---
 rtl/trace_pkg.sv | 45 ++++
 rtl/trace_sink_fifo.sv | 67 ++++++
 rtl/trace_sink.sv | 137 +++++++++++++
 tb/tb_trace_sink.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared trace packet layout, type encodings and word helper
package trace_pkg;

    localparam int TRC_PKG_W  = 256;
    localparam int TRC_WORDS  = 8;
    localparam int TRC_WORD_W = 32;

    // Field positions within a 256-bit trace packet (LSB and width)
    localparam int TRC_TYPE_LSB  = 254;
    localparam int TRC_TYPE_W    = 2;
    localparam int TRC_PRV_LSB   = 252;
    localparam int TRC_PRV_W     = 2;
    localparam int TRC_MXL_BIT   = 251;
    localparam int TRC_CYCLE_LSB = 224;
    localparam int TRC_CYCLE_W   = 27;
    localparam int TRC_PC_LSB    = 160;
    localparam int TRC_PC_W      = 64;
    localparam int TRC_INSN_LSB  = 128;
    localparam int TRC_INSN_W    = 32;
    localparam int TRC_A_LSB     = 64;
    localparam int TRC_A_W       = 64;
    localparam int TRC_B_LSB     = 0;
    localparam int TRC_B_W       = 64;

    typedef enum logic [1:0] {
        TRC_ST   = 2'd0,
        TRC_LD   = 2'd1,
        TRC_REG  = 2'd2,
        TRC_TRAP = 2'd3
    } trc_type_e;

    typedef enum logic {
        SNK_IDLE = 1'b0,
        SNK_SEND = 1'b1
    } sink_state_e;

    // Word 0 is the most significant 32 bits; shifting word idx to the top selects it
    function automatic logic [TRC_WORD_W-1:0] trc_word(input logic [TRC_PKG_W-1:0] p,
                                                        input logic [2:0]           idx);
        logic [TRC_PKG_W-1:0] s;
        s = p << {idx, 5'd0};
        return s[TRC_PKG_W-1 -: TRC_WORD_W];
    endfunction

endpackage

// File: rtl/trace_sink_fifo.sv
// rtl/trace_sink_fifo.sv - synchronous packet FIFO with flush and occupancy count
module trace_sink_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 256
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle
    assign do_push = push & (~full | pop) & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/trace_sink.sv
// rtl/trace_sink.sv - filters trace packets into a FIFO and serializes them as 32-bit words.
// Optional TRACE_SINK_DROP_CNT_EN enables the saturating dropped-packet counter.
module trace_sink
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [3:0]               type_mask,
    input  logic                     pkg_valid,
    input  logic [TRC_PKG_W-1:0]     pkg,
    output logic                     out_valid,
    output logic [TRC_WORD_W-1:0]    out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [2:0]  LAST_IDX = 3'(TRC_WORDS - 1);

    sink_state_e            state_q;
    sink_state_e            state_d;
    logic [2:0]             idx_q;
    logic [2:0]             idx_d;
    logic                   qualified;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [TRC_PKG_W-1:0]   head;
    logic                   overflow_q;

    assign qualified = pkg_valid & enable & type_mask[pkg[TRC_TYPE_LSB +: TRC_TYPE_W]];
    assign pop       = (state_q == SNK_SEND) & out_ready & (idx_q == LAST_IDX);
    assign push      = qualified & ~clear & (~fifo_full | pop);
    assign drop      = qualified & ~clear & fifo_full & ~pop;

    trace_sink_fifo #(
        .DEPTH (DEPTH),
        .W     (TRC_PKG_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (clear),
        .push  (push),
        .wdata (pkg),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SNK_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state_q)
            SNK_IDLE: begin
                if (!fifo_empty) begin
                    state_d = SNK_SEND;
                    idx_d   = '0;
                end
            end
            SNK_SEND: begin
                out_valid = 1'b1;
                out_data  = trc_word(head, idx_q);
                out_last  = (idx_q == LAST_IDX);
                if (out_ready) begin
                    idx_d = idx_q + 3'd1;
                    // Stay in SEND across packet boundaries so streaming has no bubble
                    if (pop && (fifo_cnt == CW'(1)) && !push) begin
                        state_d = SNK_IDLE;
                    end
                end
            end
            default: begin
                state_d = SNK_IDLE;
                idx_d   = '0;
            end
        endcase
        if (clear) begin
            state_d = SNK_IDLE;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q <= 1'b0;
        end else if (clear) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;

`ifdef TRACE_SINK_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt_q <= '0;
        end else if (clear) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_trace_sink.sv
// tb/tb_trace_sink.sv - self-checking bench for trace_sink against a queue-based packet model
module tb_trace_sink;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         enable = 1'b0;
    logic         clear = 1'b0;
    logic [3:0]   type_mask = 4'h0;
    logic         pkg_valid = 1'b0;
    logic [255:0] pkg = '0;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_last;
    logic         out_ready = 1'b0;
    logic [2:0]   fifo_cnt;
    logic         overflow;
    logic [15:0]  drop_cnt;

    always #5 clk = ~clk;

    trace_sink #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .clear     (clear),
        .type_mask (type_mask),
        .pkg_valid (pkg_valid),
        .pkg       (pkg),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .fifo_cnt  (fifo_cnt),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [255:0] p, input int k);
        logic [255:0] s;
        s = p >> (32 * (7 - k));
        return s[31:0];
    endfunction

    function automatic logic [255:0] mkpkt(input logic [1:0] t);
        logic [255:0] p;
        for (int k = 0; k < 8; k++) p[k*32 +: 32] = $urandom;
        p[255:254] = t;
        return p;
    endfunction

    // Model: packet queue, word position within head, sticky/drop status
    logic [255:0] mq[$];
    int           wi = 0;
    int           prev_sz = 0;
    int           m_drop = 0;
    logic         m_ovf = 1'b0;
    logic         exp_valid, hs, qual, popping, room;

    always @(negedge clk) begin
        #2;
        if (!rstn) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_fifo_cnt", fifo_cnt, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_drop_cnt", drop_cnt, 0);
            mq.delete();
            wi = 0; prev_sz = 0; m_ovf = 1'b0; m_drop = 0;
        end else begin
            exp_valid = (mq.size() > 0) && (prev_sz > 0);
            chk("out_valid", out_valid, exp_valid);
            chk("fifo_cnt", fifo_cnt, mq.size());
            chk("overflow", overflow, m_ovf);
`ifdef TRACE_SINK_DROP_CNT_EN
            chk("drop_cnt", drop_cnt, m_drop);
`else
            chk("drop_cnt", drop_cnt, 0);
`endif
            if (exp_valid) begin
                chk("out_data", out_data, word_of(mq[0], wi));
                chk("out_last", out_last, wi == 7);
            end
            hs   = exp_valid && out_ready;
            qual = pkg_valid && enable && type_mask[pkg[255:254]];
            prev_sz = mq.size();
            if (clear) begin
                mq.delete();
                wi = 0; m_ovf = 1'b0; m_drop = 0;
            end else begin
                popping = hs && (wi == 7);
                if (hs) wi = (wi + 1) % 8;
                room = (mq.size() < DEPTH) || popping;
                if (qual && !room) begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
                if (popping) void'(mq.pop_front());
                if (qual && room) mq.push_back(pkg);
            end
        end
    end

    task automatic drain(input int bound, input bit rnd, output int nlast);
        nlast = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            #1;
            if (fifo_cnt == 0 && !out_valid) return;
            if (out_valid && out_ready && out_last) nlast++;
        end
        chk("drain_timeout", {fifo_cnt, out_valid}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [255:0] p1;
    logic [255:0] p2;
    logic [31:0]  p2w0;
    int           n;
    bit           found;

    initial begin
        p1 = {4{64'h0123456789ABCDEF}};
        repeat (3) @(negedge clk);
        rstn = 1'b1; enable = 1'b1; type_mask = 4'hF; out_ready = 1'b1;

        // single packet: latency, word order, out_last placement
        @(negedge clk); pkg_valid = 1'b1; pkg = p1;
        @(negedge clk); pkg_valid = 1'b0; #1;
        chk("single_cnt1", fifo_cnt, 1);
        chk("single_novalid", out_valid, 0);
        @(negedge clk); #1;
        chk("single_valid", out_valid, 1);
        chk("single_w0", out_data, 32'h01234567);
        chk("single_w0_last", out_last, 0);
        @(negedge clk); #1;
        chk("single_w1", out_data, 32'h89ABCDEF);
        repeat (6) @(negedge clk);
        #1;
        chk("single_w7", out_data, 32'h89ABCDEF);
        chk("single_w7_last", out_last, 1);
        @(negedge clk); #1;
        chk("single_idle", out_valid, 0);
        chk("single_cnt0", fifo_cnt, 0);

        // filter: only type 3 passes
        type_mask = 4'b1000;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk); pkg_valid = 1'b1; pkg = mkpkt(2'(t));
        end
        @(negedge clk); pkg_valid = 1'b0;
        drain(60, 1'b0, n);
        chk("filter_pkts", n, 1);
        chk("filter_drop", drop_cnt, 0);
        chk("filter_ovf", overflow, 0);

        // overflow: 6 packets into a stalled FIFO of 4
        type_mask = 4'hF;
        @(negedge clk); out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); pkg_valid = 1'b1; pkg = mkpkt(2'($urandom_range(3)));
        end
        @(negedge clk); pkg_valid = 1'b0; #1;
        chk("ovf_cnt", fifo_cnt, 4);
        chk("ovf_flag", overflow, 1);
`ifdef TRACE_SINK_DROP_CNT_EN
        chk("ovf_drop", drop_cnt, 2);
`else
        chk("ovf_drop", drop_cnt, 0);
`endif
        drain(100, 1'b0, n);
        chk("ovf_pkts", n, 4);

        // full FIFO with a push on the word-7 handshake
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); pkg_valid = 1'b1; pkg = mkpkt(2'($urandom_range(3)));
        end
        @(negedge clk); pkg_valid = 1'b0; out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); #1;
            if (out_valid && out_last) found = 1'b1;
        end
        chk("fullpop_reach", found, 1);
        pkg_valid = 1'b1; pkg = mkpkt(2'd2);
        @(negedge clk); pkg_valid = 1'b0; #1;
        chk("fullpop_cnt", fifo_cnt, 4);
        chk("fullpop_ovf", overflow, 0);
        chk("fullpop_drop", drop_cnt, 0);
        chk("fullpop_valid", out_valid, 1);
        chk("fullpop_w0", out_last, 0);
        drain(100, 1'b0, n);
        chk("fullpop_pkts", n, 4);

        // clear during word 3 with packets queued and overflow set
        @(negedge clk); out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); pkg_valid = 1'b1; pkg = mkpkt(2'($urandom_range(3)));
        end
        @(negedge clk); pkg_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        clear = 1'b1; pkg_valid = 1'b1; pkg = mkpkt(2'd0);
        @(negedge clk); clear = 1'b0; pkg_valid = 1'b0; #1;
        chk("clr_valid", out_valid, 0);
        chk("clr_cnt", fifo_cnt, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_drop", drop_cnt, 0);
        p2 = mkpkt(2'd1);
        p2w0 = p2[255:224];
        @(negedge clk); pkg_valid = 1'b1; pkg = p2;
        @(negedge clk); pkg_valid = 1'b0;
        @(negedge clk); #1;
        chk("clr_next_valid", out_valid, 1);
        chk("clr_next_w0", out_data, p2w0);
        drain(60, 1'b0, n);
        chk("clr_next_pkts", n, 1);

        // backpressure: random out_ready over three packets
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(1));
            pkg_valid = 1'b1; pkg = mkpkt(2'($urandom_range(3)));
        end
        @(negedge clk); pkg_valid = 1'b0;
        drain(300, 1'b1, n);
        chk("bp_pkts", n, 3);

        // random traffic: enable, mask, ready, occasional clear
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            enable    = ($urandom_range(7) != 0);
            if ($urandom_range(63) == 0) type_mask = 4'($urandom);
            pkg_valid = ($urandom_range(3) == 0);
            pkg       = mkpkt(2'($urandom_range(3)));
            out_ready = ($urandom_range(2) != 0);
            clear     = ($urandom_range(299) == 0);
        end
        @(negedge clk); pkg_valid = 1'b0; clear = 1'b0;
        drain(400, 1'b0, n);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
